// File: rtl/ram_region_sequencer.sv
// Shared-RAM fetch sequencer: decodes a step code into a region of the RAM and
// streams that region's addresses to the read port, stalling on ready.
module ram_region_sequencer #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned STEP_W      = 5,
  parameter int unsigned NUM_REGIONS = 8,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_ENDS =
    {13'd5460, 13'd5284, 13'd2980, 13'd1828, 13'd1252, 13'd964, 13'd820, 13'd784}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STEP_W-1:0] step,
  input  logic              start,
  input  logic              abort,
  input  logic              ready,
  output logic              re_RAM,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] firstaddr,
  output logic [ADDR_W-1:0] lastaddr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Region bounds must be non-decreasing; entries are ADDR_W-wide slices, so
  // they can never exceed the address space.
  for (genvar k = 1; k < NUM_REGIONS; k++) begin : g_check
    if (REGION_ENDS[k*ADDR_W +: ADDR_W] < REGION_ENDS[(k-1)*ADDR_W +: ADDR_W]) begin : g_err
      $error("REGION_ENDS entry %0d is smaller than entry %0d", k, k - 1);
    end
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_d, first_d, last_d;
  logic              re_d, busy_d, done_d, err_d;
  logic              hit;
  logic [ADDR_W-1:0] first_sel, last_sel;

  // Step decode: 1 -> picture region 0, 2k -> weight region k.
  always_comb begin
    hit       = 1'b0;
    first_sel = '0;
    last_sel  = '0;
    if (32'(step) == 32'd1) begin
      hit      = 1'b1;
      last_sel = REGION_ENDS[0 +: ADDR_W];
    end
    for (int k = 1; k < NUM_REGIONS; k++) begin
      if (32'(step) == 32'(2 * k)) begin
        hit       = 1'b1;
        first_sel = REGION_ENDS[(k-1)*ADDR_W +: ADDR_W];
        last_sel  = REGION_ENDS[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr;
    first_d = firstaddr;
    last_d  = lastaddr;
    re_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (hit) begin
            first_d = first_sel;
            last_d  = last_sel;
            addr_d  = first_sel;
            if (first_sel == last_sel) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_BURST;
              re_d    = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_BURST: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (ready) begin
          if (addr == lastaddr - ADDR_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            addr_d = addr + ADDR_W'(1);
            re_d   = 1'b1;
          end
        end else begin
          re_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr      <= '0;
      firstaddr <= '0;
      lastaddr  <= '0;
      re_RAM    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr      <= addr_d;
      firstaddr <= first_d;
      lastaddr  <= last_d;
      re_RAM    <= re_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_ram_region_sequencer.sv
// Directed bench for ram_region_sequencer: vector table plus multi-cycle burst scenarios.
module tb_ram_region_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort, ready, start2;
  logic [4:0]  step, step2;
  logic        re_RAM, busy, done, err;
  logic [12:0] addr, firstaddr, lastaddr;
  logic        re2, busy2, done2, err2;
  logic [12:0] addr2, first2, last2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_region_sequencer u_dut (
    .clk(clk), .rst(rst), .step(step), .start(start), .abort(abort), .ready(ready),
    .re_RAM(re_RAM), .addr(addr), .firstaddr(firstaddr), .lastaddr(lastaddr),
    .busy(busy), .done(done), .err(err)
  );

  // Second instance whose region 1 is empty (entry repeated).
  ram_region_sequencer #(
    .NUM_REGIONS(4),
    .REGION_ENDS({13'd1000, 13'd900, 13'd784, 13'd784})
  ) u_dup (
    .clk(clk), .rst(rst), .step(step2), .start(start2), .abort(abort), .ready(ready),
    .re_RAM(re2), .addr(addr2), .firstaddr(first2), .lastaddr(last2),
    .busy(busy2), .done(done2), .err(err2)
  );

  typedef struct {
    logic        rst_v;
    logic [4:0]  step_v;
    logic        start_v, abort_v, ready_v;
    logic [42:0] exp;
  } vec_t;

  function automatic logic [42:0] pack_out(input logic r, input logic [12:0] a, input logic [12:0] f,
                                           input logic [12:0] l, input logic b, input logic d,
                                           input logic e);
    return {r, a, f, l, b, d, e};
  endfunction

  function automatic vec_t mk(input logic rs, input logic [4:0] s, input logic st, input logic ab,
                              input logic rd, input logic r, input logic [12:0] a,
                              input logic [12:0] f, input logic [12:0] l, input logic b,
                              input logic d, input logic e);
    vec_t v;
    v.rst_v = rs; v.step_v = s; v.start_v = st; v.abort_v = ab; v.ready_v = rd;
    v.exp = pack_out(r, a, f, l, b, d, e);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [42:0] outs;
    return {re_RAM, addr, firstaddr, lastaddr, busy, done, err};
  endfunction

  vec_t vt[14];
  int   cnt, exp_a, dcnt;
  logic seen;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0; step = '0;
    start2 = 1'b0; step2 = '0;

    //        rst step st ab rd | re addr  first last  busy done err
    vt[0]  = mk(0, 5'd0,  0, 0, 0,  0, 0,    0,    0,    0, 0, 0);
    vt[1]  = mk(1, 5'd3,  1, 0, 0,  0, 0,    0,    0,    0, 0, 1);
    vt[2]  = mk(1, 5'd3,  0, 0, 0,  0, 0,    0,    0,    0, 0, 0);
    vt[3]  = mk(1, 5'd16, 1, 0, 0,  0, 0,    0,    0,    0, 0, 1);
    vt[4]  = mk(1, 5'd2,  1, 0, 0,  1, 784,  784,  820,  1, 0, 0);
    vt[5]  = mk(1, 5'd2,  0, 0, 0,  1, 784,  784,  820,  1, 0, 0);
    vt[6]  = mk(1, 5'd2,  0, 0, 1,  1, 785,  784,  820,  1, 0, 0);
    vt[7]  = mk(1, 5'd14, 1, 0, 0,  1, 785,  784,  820,  1, 0, 0);
    vt[8]  = mk(1, 5'd14, 0, 1, 1,  0, 785,  784,  820,  0, 0, 0);
    vt[9]  = mk(1, 5'd14, 1, 0, 0,  1, 5284, 5284, 5460, 1, 0, 0);
    vt[10] = mk(0, 5'd14, 0, 0, 0,  0, 0,    0,    0,    0, 0, 0);
    vt[11] = mk(1, 5'd1,  1, 0, 1,  1, 0,    0,    784,  1, 0, 0);
    vt[12] = mk(1, 5'd1,  0, 0, 1,  1, 1,    0,    784,  1, 0, 0);
    vt[13] = mk(0, 5'd1,  0, 0, 1,  0, 0,    0,    0,    0, 0, 0);

    #1;
    for (int i = 0; i < 14; i++) begin
      rst = vt[i].rst_v; step = vt[i].step_v; start = vt[i].start_v;
      abort = vt[i].abort_v; ready = vt[i].ready_v;
      tick();
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(vt[i].exp));
    end
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
    tick();

    // Full picture region with ready high; a start mid-burst must be ignored.
    step = 5'd1; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 784; i++) begin
      chk($sformatf("t1_addr%0d", i), 64'({re_RAM, addr}), 64'({1'b1, 13'(i)}));
      start = (i == 100); step = (i == 100) ? 5'd14 : 5'd1;
      tick();
    end
    start = 1'b0;
    chk("t1_done", 64'({re_RAM, done, busy, firstaddr, lastaddr}), 64'({3'b011, 13'd0, 13'd784}));
    tick();
    chk("t1_idle", 64'({done, busy}), 64'd0);

    // Region 1 with ready alternating 0,1 per read cycle.
    step = 5'd2; start = 1'b1; ready = 1'b0;
    tick();
    start = 1'b0; cnt = 0; exp_a = 784; dcnt = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
        dcnt++;
      end else if (re_RAM) begin
        chk("t2_addr", 64'(addr), 64'(exp_a));
        cnt++;
        ready = (cnt % 2 == 0);
        if (ready) exp_a++;
        tick();
      end else begin
        tick();
      end
    end
    chk("t2_seen_done", 64'(seen), 64'd1);
    chk("t2_reads", 64'(cnt), 64'd72);
    chk("t2_end_addr", 64'(exp_a), 64'd820);
    tick();
    chk("t2_single_done", 64'({done, busy}), 64'd0);

    // Last weight region, then an unmapped start keeps the bounds.
    step = 5'd14; start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0; cnt = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (re_RAM) cnt++;
      tick();
    end
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_reads", 64'(cnt), 64'd176);
    chk("t3_bounds", 64'({firstaddr, lastaddr}), 64'({13'd5284, 13'd5460}));
    tick();
    step = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_err", 64'({err, busy, firstaddr, lastaddr}), 64'({2'b10, 13'd5284, 13'd5460}));
    tick();
    chk("t3_err_pulse", 64'(err), 64'd0);

    // Abort at 800, then restart region 2.
    step = 5'd2; start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (addr == 13'd800) seen = 1'b1;
      else tick();
    end
    chk("t4_reach800", 64'(seen), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort", 64'({re_RAM, done, busy}), 64'd0);
    tick();
    chk("t4_no_done", 64'({re_RAM, done, busy}), 64'd0);
    step = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_restart", 64'({re_RAM, addr, firstaddr, lastaddr}),
        64'({1'b1, 13'd820, 13'd820, 13'd964}));
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Empty region: done follows start with no reads.
    step2 = 5'd2; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("t5_done", 64'({re2, done2, busy2, first2, last2}), 64'({3'b011, 13'd784, 13'd784}));
    tick();
    chk("t5_idle", 64'({re2, done2, busy2}), 64'd0);

    // Reset mid-burst at address 1000.
    step = 5'd6; start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (addr == 13'd1000) seen = 1'b1;
      else tick();
    end
    chk("t6_reach1000", 64'(seen), 64'd1);
    rst = 1'b0;
    tick();
    chk("t6_reset", 64'(outs()), 64'd0);
    rst = 1'b1;
    tick();
    chk("t6_no_done", 64'({done, busy, re_RAM}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
